// File: rtl/rgb_fader.sv
// rgb_fader: fades an RGB colour and a brightness level, one unit per step
// tick, toward a commanded target, then holds for a programmable number of
// steps before reporting completion.
//
// Build option: define RGB_FADER_QUEUE_EN to add a 4-entry command FIFO
// that accepts commands while busy and chains them without an idle cycle.
//
// Ports:
//   clk            - single clock for all state
//   resetn         - asynchronous active-low reset
//   cmd_valid      - a command is offered
//   cmd_ready      - the block can accept a command
//   cmd_color      - target colour {red[23:16], green[15:8], blue[7:0]}
//   cmd_brightness - target brightness 0..100 (larger values clamp to 100)
//   cmd_hold       - steps to hold once the target is reached
//   red/green/blue - current colour (registered)
//   brightness     - current brightness (registered)
//   busy           - high while fading or holding
//   done           - one-cycle pulse when a command completes
module rgb_fader #(
    parameter int unsigned STEP_DIV = 100000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_color,
    input  logic [6:0]  cmd_brightness,
    input  logic [15:0] cmd_hold,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic [6:0]  brightness,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    typedef enum logic [1:0] {IDLE, FADE, HOLD} state_t;

    typedef struct packed {
        logic [23:0] color;
        logic [6:0]  bri;
        logic [15:0] hold;
    } cmd_t;

    state_t        state, state_nxt;
    cmd_t          in_cmd, load_cmd, tgt;
    logic [CW-1:0] step_cnt;
    logic [15:0]   hold_cnt;
    logic          ready_en;
    logic          push, avail, load, expire, tick, nxt_match;
    logic [7:0]    r_n, g_n, b_n;
    logic [6:0]    bri_n;

    function automatic logic [7:0] step8(input logic [7:0] cur, input logic [7:0] t);
        if (cur < t)      return cur + 8'd1;
        else if (cur > t) return cur - 8'd1;
        return cur;
    endfunction

    function automatic logic [6:0] step7(input logic [6:0] cur, input logic [6:0] t);
        if (cur < t)      return cur + 7'd1;
        else if (cur > t) return cur - 7'd1;
        return cur;
    endfunction

    assign in_cmd.color = cmd_color;
    assign in_cmd.bri   = (cmd_brightness > 7'd100) ? 7'd100 : cmd_brightness;
    assign in_cmd.hold  = cmd_hold;

    assign push = cmd_valid & cmd_ready;
    assign busy = (state != IDLE);
    assign tick = (state != IDLE) && (step_cnt == CW'(STEP_DIV - 1));

    assign r_n   = step8(red,   tgt.color[23:16]);
    assign g_n   = step8(green, tgt.color[15:8]);
    assign b_n   = step8(blue,  tgt.color[7:0]);
    assign bri_n = step7(brightness, tgt.bri);
    // HOLD is entered at the tick that makes the outputs reach the target.
    assign nxt_match = (r_n == tgt.color[23:16]) && (g_n == tgt.color[15:8]) &&
                       (b_n == tgt.color[7:0])   && (bri_n == tgt.bri);

`ifdef RGB_FADER_QUEUE_EN
    cmd_t       fifo_mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] count;
    logic       fifo_empty, pop, fifo_push;

    assign fifo_empty = (count == 3'd0);
    assign cmd_ready  = ready_en & (count != 3'd4);
    assign avail      = !fifo_empty | push;
    // An empty FIFO lets a command arriving this cycle bypass straight to load.
    assign load_cmd   = fifo_empty ? in_cmd : fifo_mem[rd_ptr];
    assign pop        = load & !fifo_empty;
    assign fifo_push  = push & !(load & fifo_empty);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)       rd_ptr <= rd_ptr + 2'd1;
            if (fifo_push && !pop)      count <= count + 3'd1;
            else if (pop && !fifo_push) count <= count - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr] <= in_cmd;
    end
`else
    assign cmd_ready = ready_en & (state == IDLE);
    assign avail     = push;
    assign load_cmd  = in_cmd;
`endif

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        expire    = 1'b0;
        unique case (state)
            IDLE: begin
                if (avail) begin
                    load      = 1'b1;
                    state_nxt = FADE;
                end
            end
            FADE: begin
                if (tick && nxt_match) state_nxt = HOLD;
            end
            HOLD: begin
                if (tick && hold_cnt == '0) begin
                    expire    = 1'b1;
                    state_nxt = IDLE;
`ifdef RGB_FADER_QUEUE_EN
                    if (avail) begin
                        load      = 1'b1;
                        state_nxt = FADE;
                    end
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            ready_en   <= 1'b0;
            done       <= 1'b0;
            tgt        <= '0;
            step_cnt   <= '0;
            hold_cnt   <= '0;
            red        <= '0;
            green      <= '0;
            blue       <= '0;
            brightness <= '0;
        end else begin
            state    <= state_nxt;
            ready_en <= 1'b1;
            done     <= expire;

            if (load) begin
                tgt      <= load_cmd;
                step_cnt <= '0;
            end else if (state != IDLE) begin
                step_cnt <= tick ? '0 : step_cnt + CW'(1);
            end else begin
                step_cnt <= '0;
            end

            if (state == FADE && tick) begin
                red        <= r_n;
                green      <= g_n;
                blue       <= b_n;
                brightness <= bri_n;
                if (nxt_match) hold_cnt <= tgt.hold;
            end else if (state == HOLD && tick && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 16'd1;
            end
        end
    end

endmodule
